// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, one quotient bit per clock
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, ZERO} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo;
  logic             neg_q, neg_r;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    a_neg   = is_signed & dividend[WIDTH-1];
    b_neg   = is_signed & divisor[WIDTH-1];
    a_mag   = a_neg ? -dividend : dividend;
    b_mag   = b_neg ? -divisor : divisor;
    // Partial remainder is always below the divisor, so WIDTH bits hold it;
    // the shifted value needs one extra bit for the trial subtract.
    shifted = {part_rem, dvd[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? ZERO : CALC;
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      ZERO:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      part_rem    <= '0;
      dvd         <= '0;
      dvs         <= '0;
      quo         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          // A zero divisor keeps the raw dividend so ZERO can return it unchanged.
          dvd      <= (divisor == '0) ? dividend : a_mag;
          dvs      <= b_mag;
          part_rem <= '0;
          quo      <= '0;
          cnt      <= '0;
          neg_q    <= a_neg ^ b_neg;
          neg_r    <= a_neg;
        end
        CALC: begin
          dvd <= {dvd[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (!diff[WIDTH]) begin
            part_rem <= diff[WIDTH-1:0];
            quo      <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            part_rem <= shifted[WIDTH-1:0];
            quo      <= {quo[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          quotient    <= neg_q ? -quo : quo;
          remainder   <= neg_r ? -part_rem : part_rem;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
        end
        ZERO: begin
          quotient    <= '1;
          remainder   <= dvd;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference result {dz, q, r} from plain 64-bit arithmetic.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    longint la, lb, lq, lr;
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    la = s ? longint'($signed(a)) : longint'({32'h0, a});
    lb = s ? longint'($signed(b)) : longint'({32'h0, b});
    lq = la / lb;
    lr = la % lb;
    return {1'b0, lq[W-1:0], lr[W-1:0]};
  endfunction

  // Transaction-level model: accept when idle, deliver results after a fixed latency.
  logic         m_busy, m_done, m_dz, p_dz;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  int           m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
      m_q <= '0; m_r <= '0; m_dz <= 1'b0;
      p_q <= '0; p_r <= '0; p_dz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_q <= p_q; m_r <= p_r; m_dz <= p_dz;
        end
        m_cnt <= m_cnt - 1;
      end else if (start) begin
        {p_dz, p_q, p_r} <= ref_div(dividend, divisor, is_signed);
        m_busy <= 1'b1;
        m_cnt  <= (divisor == '0) ? 1 : W + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", W'(busy), W'(m_busy));
    chk("done", W'(done), W'(m_done));
    chk("quotient", quotient, m_q);
    chk("remainder", remainder, m_r);
    chk("div_by_zero", W'(div_by_zero), W'(m_dz));
  end

  // Issue one operation and check literal results and latency; optionally
  // fire an extra start while busy (after edge k+4, so sampled at edge k+5).
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input int elat, input bit poke);
    int n;
    n = 0;
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    @(posedge clk); #1;
    start = 1'b0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (poke && n == 4) begin
        start = 1'b1; dividend = 50; divisor = 5; is_signed = 1'b0;
      end else if (poke && n == 5) begin
        start = 1'b0;
      end
      if (done) break;
    end
    chk({name, " latency"}, W'(n), W'(elat));
    chk({name, " q"}, quotient, eq);
    chk({name, " r"}, remainder, er);
    chk({name, " dz"}, W'(div_by_zero), W'(edz));
    chk({name, " model q"}, m_q, eq);
    chk({name, " model r"}, m_r, er);
  endtask

  initial begin
    #2;
    chk("reset busy", W'(busy), '0);
    chk("reset q", quotient, '0);
    chk("reset r", remainder, '0);
    chk("reset dz", W'(div_by_zero), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("u100/7", 100, 7, 1'b0, 14, 2, 1'b0, 33, 1'b0);
    // Back-to-back starts from the done cycle from here on.
    run_op("s-7/2", -32'sd7, 2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
    run_op("s7/-2", 7, -32'sd2, 1'b1, 32'hFFFF_FFFD, 32'h1, 1'b0, 33, 1'b0);
    run_op("s-100/-7", -32'sd100, -32'sd7, 1'b1, 14, 32'hFFFF_FFFE, 1'b0, 33, 1'b0);
    run_op("u5/0", 5, 0, 1'b0, 32'hFFFF_FFFF, 5, 1'b1, 1, 1'b0);
    run_op("u9/3", 9, 3, 1'b0, 3, 0, 1'b0, 33, 1'b0);
    run_op("s5/0", 5, 0, 1'b1, 32'hFFFF_FFFF, 5, 1'b1, 1, 1'b0);
    run_op("sMIN/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0, 1'b0, 33, 1'b0);
    run_op("uMIN/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 32'h8000_0000, 1'b0, 33, 1'b0);
    run_op("uMAX/1", 32'hFFFF_FFFF, 1, 1'b0, 32'hFFFF_FFFF, 0, 1'b0, 33, 1'b0);
    run_op("ignored", 100, 7, 1'b0, 14, 2, 1'b0, 33, 1'b1);

    // Asynchronous reset in the middle of an operation.
    start = 1'b1; dividend = 100; divisor = 7; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort busy", W'(busy), '0);
    chk("abort done", W'(done), '0);
    chk("abort q", quotient, '0);
    chk("abort r", remainder, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort no done", W'(done), '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after reset", 1000, 33, 1'b0, 30, 10, 1'b0, 33, 1'b0);

    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
